// File: rtl/pbuf_loader_pkg.sv
// Shared definitions for the programming-buffer chain loader.
//   state_t        : loader FSM states (one pass through SETUP..GAP1 per chain bit)
//   DEF_CHAIN_LEN  : default number of configuration bits in the chain
//   DEF_PHASE_CYC  : default clk cycles each programming clock phase is high
//   DEF_GAP_CYC    : default clk cycles both programming clocks are low between phases
package pbuf_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PH0,
    GAP0,
    PH1,
    GAP1
  } state_t;

  localparam int unsigned DEF_CHAIN_LEN = 6;
  localparam int unsigned DEF_PHASE_CYC = 2;
  localparam int unsigned DEF_GAP_CYC   = 1;

endpackage

// File: rtl/pbuf_phase_gen.sv
// Sequencer for the two-phase programming clocks of one load.
// Ports:
//   clk, rst    : block clock, synchronous active-high reset
//   start       : load request, honoured only in IDLE
//   last_bit    : current bit is the final chain bit (from the bit counter)
//   state       : registered FSM state
//   prog_clk0   : registered first-phase clock, high exactly in PH0
//   prog_clk1   : registered second-phase clock, high exactly in PH1
//   setup_next  : the next state is SETUP (used to launch a new data bit)
//   bit_end     : this cycle is the final GAP1 cycle of a bit
module pbuf_phase_gen
  import pbuf_loader_pkg::*;
#(
  parameter int unsigned PHASE_CYC = DEF_PHASE_CYC,
  parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   last_bit,
  output state_t state,
  output logic   prog_clk0,
  output logic   prog_clk1,
  output logic   setup_next,
  output logic   bit_end
);

  localparam int unsigned MAX_CYC = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          phase_last;
  logic          gap_last;

  assign phase_last = (cnt == CW'(PHASE_CYC - 1));
  assign gap_last   = (cnt == CW'(GAP_CYC - 1));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_end    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SETUP;
      end
      SETUP: begin
        state_next = PH0;
        cnt_next   = '0;
      end
      PH0: begin
        if (phase_last) begin
          state_next = GAP0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      GAP0: begin
        if (gap_last) begin
          state_next = PH1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      PH1: begin
        if (phase_last) begin
          state_next = GAP1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      GAP1: begin
        if (gap_last) begin
          bit_end    = 1'b1;
          cnt_next   = '0;
          state_next = last_bit ? IDLE : SETUP;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign setup_next = (state_next == SETUP);

  // Clocks are decoded from the next state so that they come straight from
  // flops yet line up exactly with the PH0/PH1 state cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      prog_clk0 <= 1'b0;
      prog_clk1 <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      prog_clk0 <= (state_next == PH0);
      prog_clk1 <= (state_next == PH1);
    end
  end

endmodule

// File: rtl/pbuf_loader.sv
// Serial loader for a two-phase (master/slave) configuration chain.
// Shifts cfg_word into the chain MSB first while reading the previous chain
// image back from prog_out, which is presented on rb_word when the load ends.
// Ports:
//   clk, rst   : block clock, synchronous active-high reset
//   start      : one-cycle load request (ignored while busy)
//   cfg_word   : image to load, sampled on the accepted start cycle
//   busy       : load in progress
//   done       : one-cycle pulse at load completion
//   rb_word    : chain contents captured during the last completed load
//   prog_in    : serial data to the chain
//   prog_clk0  : master-capture programming clock
//   prog_clk1  : slave-transfer programming clock
//   prog_out   : serial data from the last chain stage
module pbuf_loader
  import pbuf_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned PHASE_CYC = DEF_PHASE_CYC,
  parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] cfg_word,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rb_word,
  output logic                 prog_in,
  output logic                 prog_clk0,
  output logic                 prog_clk1,
  input  logic                 prog_out
);

  localparam int unsigned BW = $clog2(CHAIN_LEN + 1);

  state_t               state;
  logic                 setup_next;
  logic                 bit_end;
  logic                 last_bit;
  logic                 accept;
  logic [CHAIN_LEN-1:0] shift_q;
  logic [CHAIN_LEN-1:0] cap_q;
  logic [BW-1:0]        bit_cnt;

  assign accept   = (state == IDLE) && start;
  assign last_bit = (bit_cnt == BW'(CHAIN_LEN - 1));
  assign busy     = (state != IDLE);

  pbuf_phase_gen #(
    .PHASE_CYC (PHASE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_phase_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .last_bit   (last_bit),
    .state      (state),
    .prog_clk0  (prog_clk0),
    .prog_clk1  (prog_clk1),
    .setup_next (setup_next),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cap_q   <= '0;
      bit_cnt <= '0;
      rb_word <= '0;
      prog_in <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      // The first bit is taken straight from cfg_word so it is on prog_in
      // in the very first SETUP cycle; shift_q holds the remaining bits.
      if (accept) begin
        prog_in <= cfg_word[CHAIN_LEN-1];
        shift_q <= cfg_word << 1;
        bit_cnt <= '0;
      end else if (setup_next) begin
        prog_in <= shift_q[CHAIN_LEN-1];
        shift_q <= shift_q << 1;
      end

      if (state == SETUP) begin
        cap_q <= (cap_q << 1) | CHAIN_LEN'(prog_out);
      end

      if (bit_end) begin
        if (last_bit) begin
          done    <= 1'b1;
          rb_word <= cap_q;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pbuf_loader.sv
// Self-checking bench: pbuf_loader driving a behavioural 6-stage two-phase
// chain whose stages enable a bank of six buffers (pbuf6 model), plus a
// second loader instance with stretched phase/gap timing.
module tb_pbuf_loader;

  localparam int N    = 6;
  localparam int LAT1 = N * (1 + 2 * 2 + 2 * 1);
  localparam int LAT2 = N * (1 + 2 * 3 + 2 * 2);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] cfg_word = '0;
  logic         busy, done;
  logic [N-1:0] rb_word;
  logic         prog_in, prog_clk0, prog_clk1, prog_out;

  logic         start2 = 1'b0;
  logic [N-1:0] cfg2 = '0;
  logic         busy2, done2;
  logic [N-1:0] rb2;
  logic         pin2, c02, c12;
  logic         pout2 = 1'b0;

  // Behavioural chain: clk0 captures into masters, clk1 moves masters to slaves.
  logic [N-1:0] mst = '0;
  logic [N-1:0] slv = '0;
  // pbuf6 model: each slave bit enables one buffer; oe=1 means driven, 0 high-Z.
  logic [N-1:0] buf_in = '0;
  logic [N-1:0] buf_oe, buf_val;

  assign prog_out = slv[N-1];
  assign buf_oe   = slv;
  assign buf_val  = buf_in & slv;

  always @(posedge prog_clk0) mst <= {slv[N-2:0], prog_in};
  always @(posedge prog_clk1) slv <= mst;

  always #5 clk = ~clk;

  pbuf_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_word  (cfg_word),
    .busy      (busy),
    .done      (done),
    .rb_word   (rb_word),
    .prog_in   (prog_in),
    .prog_clk0 (prog_clk0),
    .prog_clk1 (prog_clk1),
    .prog_out  (prog_out)
  );

  pbuf_loader #(
    .CHAIN_LEN (N),
    .PHASE_CYC (3),
    .GAP_CYC   (2)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .cfg_word  (cfg2),
    .busy      (busy2),
    .done      (done2),
    .rb_word   (rb2),
    .prog_in   (pin2),
    .prog_clk0 (c02),
    .prog_clk1 (c12),
    .prog_out  (pout2)
  );

  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] ref_img = '0;
  logic         prev_pin = 1'b0;

  // Advance one clock and sample just after the edge, checking the
  // programming-clock invariants of the main instance every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (prog_clk0 && prog_clk1) begin
      errors++;
      $display("FAIL clk_overlap clk0=%b clk1=%b required never both high", prog_clk0, prog_clk1);
    end
    checks++;
    if ((prog_clk0 || prog_clk1) && (prog_in !== prev_pin)) begin
      errors++;
      $display("FAIL prog_in_stable got %b required %b while a programming clock is high", prog_in, prev_pin);
    end
    prev_pin = prog_in;
  endtask

  // One load on the main instance. ev_kind: 0 none, 1 stray start at cycle
  // ev_cyc, 2 reset at cycle ev_cyc.
  task automatic run_load(input logic [N-1:0] img, input int ev_cyc, input int ev_kind, input string tag);
    int           n;
    bit           got_done;
    bit           busy_bad;
    bit           done_seen;
    logic [N-1:0] exp_rb;
    exp_rb   = ref_img;
    cfg_word = img;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cfg_word = N'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept busy=%b done=%b required busy=1 done=0", tag, busy, done);
    end
    n        = 0;
    got_done = 1'b0;
    busy_bad = 1'b0;
    while (n < 100) begin
      if (n == ev_cyc && ev_kind == 1) begin
        start    = 1'b1;
        cfg_word = ~img;
      end
      if (n == ev_cyc && ev_kind == 2) rst = 1'b1;
      tick();
      n++;
      start = 1'b0;
      if (ev_kind == 2 && n == ev_cyc + 1) break;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
    end

    if (ev_kind == 2) begin
      checks++;
      if ({busy, done, prog_in, prog_clk0, prog_clk1} !== 5'b0 || rb_word !== '0) begin
        errors++;
        $display("FAIL %s_abort busy=%b done=%b pin=%b c0=%b c1=%b rb=%b required all 0",
                 tag, busy, done, prog_in, prog_clk0, prog_clk1, rb_word);
      end
      rst       = 1'b0;
      done_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (done || busy) done_seen = 1'b1;
      end
      checks++;
      if (done_seen) begin
        errors++;
        $display("FAIL %s_no_done got activity after abort required none", tag);
      end
      // Chain contents after an abort are whatever was partly shifted in.
      ref_img = slv;
      return;
    end

    checks++;
    if (!got_done || n != LAT1) begin
      errors++;
      $display("FAIL %s_latency got %0d (done=%b) required %0d", tag, n, got_done, LAT1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_at_done got %b required 0", tag, busy);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s_busy_during got low required high throughout load", tag);
    end
    checks++;
    if (rb_word !== exp_rb) begin
      errors++;
      $display("FAIL %s_readback got %b required %b", tag, rb_word, exp_rb);
    end
    checks++;
    if (slv !== img) begin
      errors++;
      $display("FAIL %s_chain got %b required %b", tag, slv, img);
    end
    buf_in = N'($urandom);
    #1;
    checks++;
    if (buf_oe !== img || buf_val !== (buf_in & img)) begin
      errors++;
      $display("FAIL %s_buffers oe=%b val=%b required oe=%b val=%b", tag, buf_oe, buf_val, img, buf_in & img);
    end
    ref_img = img;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, prog_in, prog_clk0, prog_clk1} !== 5'b0 || rb_word !== '0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b pin=%b c0=%b c1=%b rb=%b required all 0",
               busy, done, prog_in, prog_clk0, prog_clk1, rb_word);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_load(6'b101010, 0, 0, "load1");
    buf_in = '1;
    #1;
    checks++;
    if (buf_oe !== 6'b101010 || buf_val !== 6'b101010) begin
      errors++;
      $display("FAIL load1_ones oe=%b val=%b required oe=101010 val=101010", buf_oe, buf_val);
    end
    run_load(6'b010101, 0, 0, "load2");
    buf_in = '1;
    #1;
    checks++;
    if (buf_oe !== 6'b010101 || rb_word !== 6'b101010) begin
      errors++;
      $display("FAIL load2_fixed oe=%b rb=%b required oe=010101 rb=101010", buf_oe, rb_word);
    end
  endtask

  task automatic test_start_ignored();
    run_load(6'b110010, 10, 1, "ignore");
  endtask

  task automatic test_reset_mid();
    run_load(6'b110011, 20, 2, "rstmid");
    run_load(6'b111111, 0, 0, "fresh");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) run_load(N'($urandom), 0, 0, "rand");
  endtask

  task automatic test_params();
    int n;
    int run0;
    int hi_len;
    int gap_len;
    int low_run;
    bit after_fall;
    bit overlap;
    bit got;
    tick();
    cfg2   = N'($urandom);
    start2 = 1'b1;
    tick();
    start2     = 1'b0;
    n          = 0;
    run0       = 0;
    hi_len     = -1;
    gap_len    = -1;
    low_run    = 0;
    after_fall = 1'b0;
    overlap    = 1'b0;
    got        = 1'b0;
    while (n < 200) begin
      tick();
      n++;
      if (c02 && c12) overlap = 1'b1;
      if (after_fall && gap_len < 0) begin
        if (c12) gap_len = low_run;
        else low_run++;
      end
      if (c02) run0++;
      else if (run0 > 0 && hi_len < 0) begin
        hi_len     = run0;
        after_fall = 1'b1;
        low_run    = 1;
      end
      if (done2) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || n != LAT2) begin
      errors++;
      $display("FAIL p3g2_latency got %0d (done=%b) required %0d", n, got, LAT2);
    end
    checks++;
    if (hi_len != 3) begin
      errors++;
      $display("FAIL p3g2_clk0_high got %0d required 3", hi_len);
    end
    checks++;
    if (gap_len != 2) begin
      errors++;
      $display("FAIL p3g2_gap got %0d required 2", gap_len);
    end
    checks++;
    if (overlap || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL p3g2_overlap_busy overlap=%b busy=%b required 0 0", overlap, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
